ic_master_write_burst: RTL and testbench

//  Avalon-MM burst write master that drains the JPEG output FIFO (FF2) into DDR2.

---
 rtl/ic_master_write_burst.sv | 189 ++++++++++++++++++
 tb/tb_ic_master_write_burst.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ic_master_write_burst.sv
// ic_master_write_burst
//   Avalon-MM burst write master that drains the JPEG output FIFO (FF2) into
//   DDR2. A burst is only committed once FF2 already holds every word of it, so
//   the FIFO can never run dry in the middle of a burst. At end of image the
//   remaining words go out as one partial burst, then done pulses.
//
//   Optional build macro: IC_MW_BYTESWAP_EN
//     defined   -> each beat is byte-reversed on its way to MW_writedata
//                  (big-endian JPEG stream into little-endian memory)
//     undefined -> ff_q is passed through unchanged

module ic_master_write_burst #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BURST_MAX = 16,
  parameter int USED_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_address,
  input  logic              end_of_image,
  input  logic              ff_empty,
  input  logic [USED_W-1:0] ff_usedw,
  input  logic [DATA_W-1:0] ff_q,
  output logic              ff_readrequest,
  input  logic              MW_waitrequest,
  output logic              MW_write,
  output logic [ADDR_W-1:0] MW_writeaddress,
  output logic [7:0]        MW_burstcount,
  output logic [DATA_W-1:0] MW_writedata,
  output logic              done,
  output logic [31:0]       words_written
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int                BYTES_PER_BEAT = DATA_W / 8;
  localparam logic [USED_W-1:0] BURST_MAX_USED = USED_W'(BURST_MAX);
  localparam logic [7:0]        BURST_MAX_CNT  = 8'(BURST_MAX);
  localparam logic [ADDR_W-1:0] BEAT_STRIDE    = ADDR_W'(BYTES_PER_BEAT);

`ifdef IC_MW_BYTESWAP_EN
  // Reverse byte order of one data word (byte 0 <-> byte N-1, ...).
  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < BYTES_PER_BEAT; i++) begin
      r[8*i +: 8] = d[DATA_W-8-8*i +: 8];
    end
    return r;
  endfunction
`endif

  logic [1:0]        state_q,      state_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [7:0]        burstcount_q, burstcount_d;
  logic [7:0]        beat_cnt_q,   beat_cnt_d;
  logic [31:0]       words_q,      words_d;
  logic              eoi_q,        eoi_d;
  logic              mw_write_q,   mw_write_d;
  logic              done_q,       done_d;

  logic              beat_accept_s;
  logic              last_beat_s;

  assign beat_accept_s = mw_write_q && !MW_waitrequest;
  assign last_beat_s   = beat_accept_s && (beat_cnt_q == (burstcount_q - 8'd1));

  // Next-state logic: image sequencing, burst commit decisions and beat counting.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    burstcount_d = burstcount_q;
    beat_cnt_d   = beat_cnt_q;
    words_d      = words_q;
    mw_write_d   = mw_write_q;
    done_d       = 1'b0;

    // End-of-image is remembered until the next accepted start; a start in
    // IDLE always clears it, even if end_of_image arrives in the same cycle.
    if (start && (state_q == ST_IDLE)) begin
      eoi_d = 1'b0;
    end else if (end_of_image && (state_q != ST_IDLE)) begin
      eoi_d = 1'b1;
    end else begin
      eoi_d = eoi_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = dest_address;
          words_d = 32'd0;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (ff_usedw >= BURST_MAX_USED) begin
          burstcount_d = BURST_MAX_CNT;
          beat_cnt_d   = 8'd0;
          mw_write_d   = 1'b1;
          state_d      = ST_BURST;
        end else if (eoi_q && (ff_usedw != {USED_W{1'b0}})) begin
          // Fewer than BURST_MAX words remain, so the level fits in 8 bits.
          burstcount_d = 8'(ff_usedw);
          beat_cnt_d   = 8'd0;
          mw_write_d   = 1'b1;
          state_d      = ST_BURST;
        end else if (eoi_q && ff_empty) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_BURST: begin
        if (beat_accept_s) begin
          words_d = words_q + 32'd1;
          if (last_beat_s) begin
            // Next burst starts right after this one; wraps at 2**ADDR_W.
            addr_d     = addr_q + (ADDR_W'(burstcount_q) * BEAT_STRIDE);
            beat_cnt_d = 8'd0;
            mw_write_d = 1'b0;
            state_d    = ST_WAIT;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end else begin
          state_d = ST_BURST;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        mw_write_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any burst in flight without touching FF2.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= {ADDR_W{1'b0}};
      burstcount_q <= 8'd0;
      beat_cnt_q   <= 8'd0;
      words_q      <= 32'd0;
      eoi_q        <= 1'b0;
      mw_write_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      burstcount_q <= burstcount_d;
      beat_cnt_q   <= beat_cnt_d;
      words_q      <= words_d;
      eoi_q        <= eoi_d;
      mw_write_q   <= mw_write_d;
      done_q       <= done_d;
    end
  end

  // Pop FF2 in the same cycle the slave takes the beat (show-ahead FIFO).
  assign ff_readrequest  = beat_accept_s;
  assign MW_write        = mw_write_q;
  assign MW_writeaddress = addr_q;
  assign MW_burstcount   = burstcount_q;
  assign done            = done_q;
  assign words_written   = words_q;

`ifdef IC_MW_BYTESWAP_EN
  assign MW_writedata = byte_swap(ff_q);
`else
  assign MW_writedata = ff_q;
`endif

endmodule

// File: tb/tb_ic_master_write_burst.sv
// Self-checking bench for ic_master_write_burst: FF2 is modelled as a queue,
// and the expected Avalon traffic is derived from the word count alone
// (full bursts of 16, then one partial, contiguous addresses, FIFO order).
module tb_ic_master_write_burst;

  logic        clk = 1'b0;
  logic        reset, start, end_of_image, ff_empty, MW_waitrequest;
  logic [31:0] dest_address, ff_q;
  logic [7:0]  ff_usedw;
  logic        ff_readrequest, MW_write, done;
  logic [31:0] MW_writeaddress, MW_writedata, words_written;
  logic [7:0]  MW_burstcount;

  always #5 clk = ~clk;

  ic_master_write_burst #(.DATA_W(32), .ADDR_W(32), .BURST_MAX(16), .USED_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .dest_address(dest_address),
    .end_of_image(end_of_image), .ff_empty(ff_empty), .ff_usedw(ff_usedw), .ff_q(ff_q),
    .ff_readrequest(ff_readrequest), .MW_waitrequest(MW_waitrequest), .MW_write(MW_write),
    .MW_writeaddress(MW_writeaddress), .MW_burstcount(MW_burstcount),
    .MW_writedata(MW_writedata), .done(done), .words_written(words_written)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  bc;
    logic [31:0] data;
    bit          last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] fifo[$];
  logic [31:0] src[$];
  int          n_pass = 0, n_total = 0;
  int          cyc = 0, done_cnt = 0, done_cyc = 0, pops = 0;
  bit          mon_en = 1'b0, push_en = 1'b0, after_last = 1'b0, hold_prev = 1'b0;
  logic [31:0] push_data, prev_addr;
  logic [7:0]  prev_bc;

  function automatic logic [31:0] out_word(input logic [31:0] w);
`ifdef IC_MW_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic fifo_drive();
    ff_empty = (fifo.size() == 0);
    ff_usedw = 8'(fifo.size());
    ff_q     = (fifo.size() > 0) ? fifo[0] : 32'h0;
  endtask

  // One clock: sample settled outputs, check them, then update FF2 after the edge.
  task automatic cycle();
    beat_t e;
    bit    pop_s;
    #1;
    pop_s = (ff_readrequest === 1'b1);
    if (mon_en) begin
      cyc++;
      chk("pop_on_empty", 64'(ff_readrequest && (fifo.size() == 0)), 64'd0);
      chk("readreq_vs_accept", 64'(ff_readrequest), 64'(MW_write && !MW_waitrequest));
      if (after_last) chk("gap_after_burst", 64'(MW_write), 64'd0);
      after_last = 1'b0;
      if (hold_prev && MW_write) begin
        chk("addr_stable", 64'(MW_writeaddress), 64'(prev_addr));
        chk("bc_stable", 64'(MW_burstcount), 64'(prev_bc));
      end
      hold_prev = MW_write && MW_waitrequest;
      prev_addr = MW_writeaddress;
      prev_bc   = MW_burstcount;
      if (pop_s) pops++;
      if (MW_write && !MW_waitrequest) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_addr", 64'(MW_writeaddress), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", 64'(MW_writeaddress), 64'(e.addr));
          chk("beat_bc", 64'(MW_burstcount), 64'(e.bc));
          chk("beat_data", 64'(MW_writedata), 64'(e.data));
          after_last = e.last;
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    if (pop_s && (fifo.size() > 0)) fifo.delete(0);
    if (push_en) fifo.push_back(push_data);
    push_en      = 1'b0;
    start        = 1'b0;
    end_of_image = 1'b0;
    fifo_drive();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string p);
    #1;
    chk({p, "_mw_write"}, 64'(MW_write), 64'd0);
    chk({p, "_readreq"}, 64'(ff_readrequest), 64'd0);
    chk({p, "_done"}, 64'(done), 64'd0);
    chk({p, "_burstcount"}, 64'(MW_burstcount), 64'd0);
    chk({p, "_address"}, 64'(MW_writeaddress), 64'd0);
    chk({p, "_words"}, 64'(words_written), 64'd0);
  endtask

  // Expected beats: bursts of 16 while words remain, one partial burst last.
  task automatic build_exp(input int n, input logic [31:0] dest);
    int off, b;
    exp_q.delete();
    off = 0;
    while (off < n) begin
      b = ((n - off) >= 16) ? 16 : (n - off);
      for (int k = 0; k < b; k++)
        exp_q.push_back('{addr: dest + 32'(off * 4), bc: 8'(b),
                          data: out_word(src[off + k]), last: (k == b - 1)});
      off += b;
    end
  endtask

  // wmode: 0 no stall, 1 random stall, 2 stall pattern 1,1,0
  task automatic run_xfer(input int n, input logic [31:0] dest, input int wmode,
                          input int pre, input int maxgap, input bit rnd_start);
    int pushed, gap, pc, eoi_cyc;
    bit eoi_sent;
    build_exp(n, dest);
    for (int i = 0; i < pre; i++) fifo.push_back(src[i]);
    fifo_drive();
    pushed = pre; done_cnt = 0; pops = 0; after_last = 1'b0; hold_prev = 1'b0;
    eoi_sent = 1'b0; pc = 0; eoi_cyc = 0;
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    dest_address   = dest;
    start          = 1'b1;
    MW_waitrequest = 1'b0;
    cycle();
    for (int t = 0; t < 3000 && done_cnt == 0; t++) begin
      if (pushed < n) begin
        if (wmode == 0 || $urandom_range(0, 9) < 6) begin
          push_en = 1'b1; push_data = src[pushed]; pushed++;
        end
      end else if (!eoi_sent) begin
        if (gap == 0) begin
          end_of_image = 1'b1; eoi_sent = 1'b1; eoi_cyc = cyc + 1;
        end else begin
          gap--;
        end
      end
      if (rnd_start && $urandom_range(0, 19) == 0) start = 1'b1;
      case (wmode)
        1: MW_waitrequest = ($urandom_range(0, 99) < 35);
        2: begin MW_waitrequest = ((pc % 3) != 2); pc++; end
        default: MW_waitrequest = 1'b0;
      endcase
      cycle();
    end
    MW_waitrequest = 1'b0;
    chk("done_seen", 64'(done_cnt), 64'd1);
    repeat (3) cycle();
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("words_written", 64'(words_written), 64'(n));
    chk("pop_count", 64'(pops), 64'(n));
    chk("beats_left", 64'(exp_q.size()), 64'd0);
    chk("fifo_left", 64'(fifo.size()), 64'd0);
    if (n == 0) chk("empty_done_latency", 64'(done_cyc - eoi_cyc), 64'd2);
  endtask

  initial begin
    logic [31:0] sw_exp;
    logic [31:0] d;
    int          n;
    reset = 1'b1; start = 1'b0; end_of_image = 1'b0; MW_waitrequest = 1'b0;
    dest_address = 32'h0;
    fifo_drive();
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    chk_reset("reset");

    // Two full bursts at 0x1000 / 0x1040
    src.delete();
    for (int i = 0; i < 32; i++) src.push_back(32'(i));
    run_xfer(32, 32'h1000, 0, 32, 0, 1'b0);

    // 20 words: 16 + partial 4
    src.delete();
    for (int i = 0; i < 20; i++) src.push_back(32'h100 + 32'(i));
    run_xfer(20, 32'h0004_0000, 0, 20, 0, 1'b0);

    // Backpressure pattern during one full burst
    src.delete();
    for (int i = 0; i < 16; i++) src.push_back($urandom);
    run_xfer(16, 32'h0008_0000, 2, 16, 0, 1'b0);

    // Empty image
    src.delete();
    run_xfer(0, 32'h0009_0000, 0, 0, 0, 1'b0);

    // Reset after beat 5 of 16
    src.delete();
    fifo.delete();
    for (int i = 0; i < 16; i++) begin
      src.push_back($urandom);
      fifo.push_back(src[i]);
    end
    fifo_drive();
    build_exp(16, 32'h2000);
    pops = 0; after_last = 1'b0; hold_prev = 1'b0;
    dest_address = 32'h2000; start = 1'b1; MW_waitrequest = 1'b0;
    cycle();
    for (int t = 0; t < 100 && pops < 5; t++) cycle();
    chk("pre_reset_beats", 64'(pops), 64'd5);
    reset = 1'b1; MW_waitrequest = 1'b1;
    cycle();
    reset = 1'b0; MW_waitrequest = 1'b0;
    exp_q.delete(); after_last = 1'b0; hold_prev = 1'b0;
    chk_reset("mid_burst_reset");
    chk("fifo_untouched", 64'(fifo.size()), 64'd11);
    for (int i = 0; i < 5; i++) fifo.push_back($urandom);
    fifo_drive();
    pops = 0;
    repeat (5) cycle();
    chk("idle_after_reset_pops", 64'(pops), 64'd0);
    fifo.delete();
    fifo_drive();
    src.delete();
    for (int i = 0; i < 24; i++) src.push_back($urandom);
    run_xfer(24, 32'h3000, 1, 24, 2, 1'b0);

    // Byte swap on the data path
`ifdef IC_MW_BYTESWAP_EN
    sw_exp = 32'hDDCCBBAA;
`else
    sw_exp = 32'hAABBCCDD;
`endif
    fifo.push_back(32'hAABBCCDD);
    fifo_drive();
    #1;
    chk("byteswap", 64'(MW_writedata), 64'(sw_exp));
    fifo.delete();
    fifo_drive();
    src.delete();
    src.push_back(32'hAABBCCDD); src.push_back(32'h01020304); src.push_back(32'hCAFEF00D);
    run_xfer(3, 32'h4000, 0, 3, 0, 1'b0);

    // Randomized images: sizes, streaming, stalls, late eoi, stray starts, address wrap
    for (int r = 0; r < 16; r++) begin
      n = int'($urandom_range(0, 50));
      d = (r == 0) ? 32'hFFFF_FFC0 : $urandom;
      src.delete();
      for (int i = 0; i < n; i++) src.push_back($urandom);
      run_xfer(n, d, 1, int'($urandom_range(0, n)), 4, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
